zx_sd_sequencer: RTL and testbench



---
 rtl/zx_sd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_zx_sd_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_sd_sequencer.sv
// Scan-doubler sequencer for the ZX80/ZX81 VGA path.
// Decodes composite sync into line/frame edges, runs the 13 MHz column
// counters, addresses the 1024x1 double-bank line buffer (write at the ZX
// pixel rate, read at twice that) and generates VGA hs/vs/de.
module zx_sd_sequencer #(
    parameter int LINE_LEN   = 414,
    parameter int VS_THRESH  = 90,
    parameter int H_DE_START = 64,
    parameter int H_DE_END   = 364,
    parameter int HS_START   = 384,
    parameter int V_DE_START = 16,
    parameter int V_DE_END   = 296
) (
    input  logic       clk13,
    input  logic       n_reset,
    input  logic       csync,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [9:0] rd_addr,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic       scanline,
    output logic [9:0] line_cnt,
    output logic       resync
);

    // Parameters sized to the counters they are compared against
    localparam logic [8:0] COL_LAST = 9'(LINE_LEN - 1);
    localparam logic [8:0] COL_LEN  = 9'(LINE_LEN);
    localparam logic [7:0] VS_TH    = 8'(VS_THRESH);
    localparam logic [8:0] HDE_S    = 9'(H_DE_START);
    localparam logic [8:0] HDE_E    = 9'(H_DE_END);
    localparam logic [8:0] HS_S     = 9'(HS_START);
    localparam logic [9:0] VDE_S    = 10'(V_DE_START);
    localparam logic [9:0] VDE_E    = 10'(V_DE_END);

    // Sync decode state
    logic       csd_q;
    logic [7:0] sync_len_q, sync_len_d;
    logic       vs_q, vs_d;

    // Line / column state
    logic       wr_bank_q, wr_bank_d;
    logic [9:0] line_cnt_q, line_cnt_d;
    logic       scanline_q, scanline_d;
    logic [8:0] sd_col_q, sd_col_d;
    logic [9:0] zx_col_q, zx_col_d;

    // Registered VGA timing outputs
    logic       hs_q, hs_d;
    logic       de_q, de_d;
    logic       resync_q, resync_d;

    // Decoded events
    logic       edge_ev;
    logic       hsync_ev;
    logic       vs_start;
    logic       col_wrap;
    logic       h_de;
    logic       v_de;

    // Sync-low length, counting the current cycle, saturating at 255
    always_comb begin
        sync_len_d = sync_len_q;
        if (csync)
            sync_len_d = '0;
        else if (sync_len_q != 8'hFF)
            sync_len_d = sync_len_q + 8'd1;
    end

    // The end of a sync pulse only counts if a low cycle has actually been
    // seen since reset, so the cycle after reset release (csD cleared, csync
    // already high) is not taken for the end of a pulse.
    assign edge_ev  = csync & ~csd_q & (sync_len_q != 8'd0);
    assign hsync_ev = edge_ev & (sync_len_q < VS_TH);
    assign vs_start = ~csync & (sync_len_d == VS_TH);
    assign col_wrap = (sd_col_q == COL_LAST);
    assign h_de     = (sd_col_q >= HDE_S) & (sd_col_q < HDE_E);
    assign v_de     = (line_cnt_q >= VDE_S) & (line_cnt_q < VDE_E);

    // Next-state for vsync and the per-line counters
    always_comb begin
        vs_d       = vs_q;
        wr_bank_d  = wr_bank_q ^ edge_ev;
        line_cnt_d = line_cnt_q;
        scanline_d = scanline_q;
        sd_col_d   = sd_col_q + 9'd1;
        zx_col_d   = zx_col_q;

        if (csync)
            vs_d = 1'b0;
        else if (vs_start)
            vs_d = 1'b1;

        // vsync start and an edge never coincide (one needs csync low,
        // the other csync high), so the clear and increment are exclusive
        if (vs_start)
            line_cnt_d = '0;
        else if (edge_ev && line_cnt_q != 10'h3FF)
            line_cnt_d = line_cnt_q + 10'd1;

        if (hsync_ev || col_wrap)
            sd_col_d = '0;

        // Clearing at vsync wins over a toggle from a column restart
        if (vs_start)
            scanline_d = 1'b0;
        else if (hsync_ev || col_wrap)
            scanline_d = ~scanline_q;

        // ZX column only realigns on hsync; frame edges leave it running
        if (hsync_ev)
            zx_col_d = '0;
        else if (zx_col_q != 10'h3FF)
            zx_col_d = zx_col_q + 10'd1;
    end

    // Registered outputs derived from the current counter values
    always_comb begin
        hs_d     = (sd_col_q >= HS_S);
        de_d     = h_de & v_de;
        resync_d = hsync_ev & ~col_wrap;
    end

    // Sync decode registers
    always_ff @(posedge clk13) begin
        if (!n_reset) begin
            csd_q      <= 1'b0;
            sync_len_q <= '0;
            vs_q       <= 1'b0;
        end else begin
            csd_q      <= csync;
            sync_len_q <= sync_len_d;
            vs_q       <= vs_d;
        end
    end

    // Line buffer bank, line/column counters and VGA timing registers
    always_ff @(posedge clk13) begin
        if (!n_reset) begin
            wr_bank_q  <= 1'b0;
            line_cnt_q <= '0;
            scanline_q <= 1'b0;
            sd_col_q   <= '0;
            zx_col_q   <= '0;
            hs_q       <= 1'b0;
            de_q       <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            line_cnt_q <= line_cnt_d;
            scanline_q <= scanline_d;
            sd_col_q   <= sd_col_d;
            zx_col_q   <= zx_col_d;
            hs_q       <= hs_d;
            de_q       <= de_d;
            resync_q   <= resync_d;
        end
    end

    // RAM addresses come straight from registers; the two banks always
    // differ in bit 9, so reads never touch the bank being written
    assign wr_en    = zx_col_q[0] & (zx_col_q[9:1] < COL_LEN);
    assign wr_addr  = {wr_bank_q, zx_col_q[9:1]};
    assign rd_addr  = {~wr_bank_q, sd_col_q};
    assign hs       = hs_q;
    assign vs       = vs_q;
    assign de       = de_q;
    assign scanline = scanline_q;
    assign line_cnt = line_cnt_q;
    assign resync   = resync_q;

endmodule

// File: tb/tb_zx_sd_sequencer.sv
// Testbench for zx_sd_sequencer: timestamp-based reference model plus
// scenario checks for reset, hsync lock, vsync classification, banks,
// display enable, mid-line reset and random sync streams.
module tb_zx_sd_sequencer;

    localparam int LL = 414;
    localparam int VT = 90;

    logic       clk13 = 1'b0;
    logic       n_reset = 1'b0;
    logic       csync = 1'b1;
    logic       wr_en, hs, vs, de, scanline, resync;
    logic [9:0] wr_addr, rd_addr, line_cnt;
    logic [35:0] dut_vec;

    zx_sd_sequencer dut (
        .clk13(clk13), .n_reset(n_reset), .csync(csync),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .hs(hs), .vs(vs), .de(de), .scanline(scanline),
        .line_cnt(line_cnt), .resync(resync)
    );

    always #5 clk13 = ~clk13;

    assign dut_vec = {wr_en, wr_addr, rd_addr, hs, vs, de, scanline, line_cnt, resync};

    int checks = 0;
    int passed = 0;
    int nprint = 0;

    // Reference model: columns are tracked as time since the last alignment
    // point rather than as counters.
    int cyc = 0;          // index of the currently visible cycle
    int col_anchor = 0;   // cycle at which sd_col last restarted by hsync/reset
    int zx_anchor = 0;    // cycle at which zx_col last restarted
    int low_run = 0;      // consecutive low csync samples so far
    int edges = 0;        // sync-pulse ends since reset
    int m_line = 0;
    int m_prev_sd = 0;
    int m_prev_line = 0;
    bit m_scan = 0, m_vs = 0, m_hs = 0, m_de = 0, m_resync = 0;

    function automatic logic [35:0] exp_vec();
        int  sd, zx;
        logic bank, we;
        sd = (cyc - col_anchor) % LL;
        zx = cyc - zx_anchor;
        if (zx > 1023) zx = 1023;
        bank = edges[0];
        we = ((zx % 2) == 1) && ((zx / 2) < LL);
        exp_vec = {we, bank, 9'(zx / 2), ~bank, 9'(sd), m_hs, m_vs, m_de, m_scan,
                   10'(m_line), m_resync};
    endfunction

    task automatic model_step(input logic cs, input logic rn);
        int c, sd_c;
        bit ev, hev, clr;
        c = cyc;
        sd_c = (c - col_anchor) % LL;
        clr = 0;
        if (!rn) begin
            col_anchor = c + 1; zx_anchor = c + 1;
            low_run = 0; edges = 0; m_line = 0;
            m_scan = 0; m_vs = 0; m_hs = 0; m_de = 0; m_resync = 0;
            m_prev_sd = 0; m_prev_line = 0;
        end else begin
            m_prev_sd = sd_c;
            m_prev_line = m_line;
            ev  = cs && (low_run > 0);
            hev = ev && (low_run < VT);
            m_hs = (sd_c >= 384);
            m_de = (sd_c >= 64) && (sd_c < 364) && (m_line >= 16) && (m_line < 296);
            m_resync = hev && (sd_c != LL - 1);
            if (hev) begin col_anchor = c + 1; zx_anchor = c + 1; end
            if (ev) begin edges++; if (m_line < 1023) m_line++; end
            low_run = cs ? 0 : ((low_run < 255) ? low_run + 1 : 255);
            if (cs) m_vs = 0;
            else if (low_run == VT) begin m_vs = 1; m_line = 0; m_scan = 0; clr = 1; end
            if (!clr && (((c + 1 - col_anchor) % LL) == 0)) m_scan = !m_scan;
        end
    endtask

    task automatic tick(input logic cs, input logic rn);
        csync = cs;
        n_reset = rn;
        @(posedge clk13);
        model_step(cs, rn);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int rs = 0, hs_cnt = 0, z0 = -1, z1 = -1;
        logic bank_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                nprint++;
                if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end else passed++;
        end
        checks++;
        if ({wr_en, wr_addr, hs, vs, de, scanline, line_cnt, resync} !== 26'h0 || rd_addr !== 10'h200)
            $display("FAIL reset_outputs got=%h rd=%h exp=0 rd=200",
                     {wr_en, wr_addr, hs, vs, de, scanline, line_cnt, resync}, rd_addr);
        else passed++;
        for (int i = 0; i < 2 * LL + 10; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                nprint++;
                if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end else passed++;
            if (resync) rs++;
            if (wr_addr[9]) bank_seen = 1;
            if (i < LL && hs) hs_cnt++;
            if (rd_addr[8:0] == 9'd0) begin
                if (z0 < 0) z0 = i; else if (z1 < 0) z1 = i;
            end
        end
        checks++;
        if (rs !== 0) $display("FAIL freerun_resync got=%0d exp=0", rs); else passed++;
        checks++;
        if (bank_seen !== 1'b0) $display("FAIL freerun_bank got=%0d exp=0", bank_seen); else passed++;
        checks++;
        if (z0 !== LL - 1) $display("FAIL first_wrap got=%0d exp=%0d", z0, LL - 1); else passed++;
        checks++;
        if (z1 - z0 !== LL) $display("FAIL wrap_period got=%0d exp=%0d", z1 - z0, LL); else passed++;
        checks++;
        if (hs_cnt !== 30) $display("FAIL hs_per_line got=%0d exp=30", hs_cnt); else passed++;
    endtask

    task automatic test_hsync_lock();
        int delay, rs = 0, tog_n = 0, wen = 0;
        int tog[4];
        logic prev_bank;
        delay = $urandom_range(50, 400);
        if (((cyc - col_anchor) % LL + delay + 30) % LL == LL - 1) delay++;
        prev_bank = wr_addr[9];
        for (int i = 0; i < delay + 4 * 828; i++) begin
            tick((i < delay) ? 1'b1 : (((i - delay) % 828) >= 30), 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                nprint++;
                if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end else passed++;
            if (resync) rs++;
            if (wr_addr[9] != prev_bank) begin
                if (tog_n < 4) tog[tog_n] = i;
                tog_n++;
                prev_bank = wr_addr[9];
            end
            if (tog_n == 2 && wr_en) wen++;
        end
        checks++;
        if (rs !== 1) $display("FAIL lock_resync got=%0d exp=1", rs); else passed++;
        checks++;
        if (tog_n !== 4) $display("FAIL lock_toggles got=%0d exp=4", tog_n); else passed++;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (tog[k] - tog[k-1] !== 828)
                $display("FAIL bank_period%0d got=%0d exp=828", k, tog[k] - tog[k-1]);
            else passed++;
        end
        checks++;
        if (wen !== LL) $display("FAIL wr_en_per_line got=%0d exp=%0d", wen, LL); else passed++;
    endtask

    task automatic test_vsync();
        int lows[3] = '{89, 90, 400};
        int exp_vs[3] = '{0, 1, 311};
        for (int p = 0; p < 3; p++) begin
            int vcnt = 0, rs = 0, line_bad = 0, first_vs = -1;
            for (int i = 0; i < lows[p] + 800; i++) begin
                tick(i >= lows[p], 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    nprint++;
                    if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end else passed++;
                if (vs) begin
                    vcnt++;
                    if (first_vs < 0) first_vs = i;
                    if (line_cnt != 10'd0) line_bad++;
                end
                if (resync) rs++;
                if (p == 2 && i == lows[p]) begin
                    checks++;
                    if (rd_addr[8:0] !== 9'((cyc - col_anchor) % LL) || rd_addr[8:0] === 9'd0)
                        $display("FAIL frame_no_realign got=%0d exp=%0d", rd_addr[8:0], (cyc - col_anchor) % LL);
                    else passed++;
                    checks++;
                    if (line_cnt !== 10'd1) $display("FAIL line_after_frame got=%0d exp=1", line_cnt); else passed++;
                end
            end
            checks++;
            if (vcnt !== exp_vs[p]) $display("FAIL vs_len_pulse%0d got=%0d exp=%0d", lows[p], vcnt, exp_vs[p]);
            else passed++;
            if (p > 0) begin
                checks++;
                if (first_vs !== VT - 1) $display("FAIL vs_rise_pulse%0d got=%0d exp=%0d", lows[p], first_vs, VT - 1);
                else passed++;
                checks++;
                if (rs !== 0 || line_bad !== 0)
                    $display("FAIL frame_edge_pulse%0d resync=%0d line_bad=%0d exp=0/0", lows[p], rs, line_bad);
                else passed++;
            end
        end
    endtask

    task automatic test_banks();
        int k = 0, seq_bad = 0, bank_bad = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 828; i++) begin
                tick(i >= 30, 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    nprint++;
                    if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end else passed++;
                if (wr_addr[9] === rd_addr[9]) bank_bad++;
                if (i == 30) begin
                    if (p > 0) begin
                        checks++;
                        if (k !== LL) $display("FAIL wr_strobes_line%0d got=%0d exp=%0d", p, k, LL); else passed++;
                    end
                    k = 0;
                end
                if (wr_en) begin
                    if (p > 0 || i >= 30) begin
                        if (wr_addr[8:0] !== 9'(k)) seq_bad++;
                    end
                    k++;
                end
            end
        end
        checks++;
        if (bank_bad !== 0) $display("FAIL bank_overlap got=%0d exp=0", bank_bad); else passed++;
        checks++;
        if (seq_bad !== 0) $display("FAIL wr_addr_seq got=%0d exp=0", seq_bad); else passed++;
    endtask

    task automatic test_de();
        int de_bad = 0, hs_bad = 0, de_early = 0, de_mid = 0, de_late = 0, hs_seen = 0;
        for (int i = 0; i < 290; i++) tick(i >= 90, 1'b1);
        for (int p = 0; p < 302; p++) begin
            int len;
            len = (p < 22) ? 500 : 100;
            for (int i = 0; i < len; i++) begin
                logic e_de, e_hs;
                tick(i >= 20, 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    nprint++;
                    if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end else passed++;
                e_de = (m_prev_sd >= 64 && m_prev_sd < 364 && m_prev_line >= 16 && m_prev_line < 296);
                e_hs = (m_prev_sd >= 384 && m_prev_sd <= 413);
                if (de !== e_de) de_bad++;
                if (hs !== e_hs) hs_bad++;
                if (hs) hs_seen++;
                if (de && m_prev_line < 16) de_early++;
                if (de && m_prev_line >= 16 && m_prev_line < 296) de_mid++;
                if (de && m_prev_line >= 296) de_late++;
            end
        end
        checks++;
        if (de_bad !== 0) $display("FAIL de_window got=%0d exp=0", de_bad); else passed++;
        checks++;
        if (hs_bad !== 0 || hs_seen == 0) $display("FAIL hs_window bad=%0d seen=%0d exp=0/>0", hs_bad, hs_seen);
        else passed++;
        checks++;
        if (de_early !== 0 || de_late !== 0 || de_mid == 0)
            $display("FAIL de_vlines early=%0d mid=%0d late=%0d exp=0/>0/0", de_early, de_mid, de_late);
        else passed++;
        checks++;
        if (line_cnt !== 10'd303) $display("FAIL de_line_cnt got=%0d exp=303", line_cnt); else passed++;
    endtask

    task automatic test_mid_reset();
        int guard = 0, rs = 0;
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
        while (((cyc - col_anchor) % LL) != 200 && guard < 1000) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                nprint++;
                if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end else passed++;
            guard++;
        end
        checks++;
        if (guard >= 1000) $display("FAIL wait_col200 got=timeout exp=col 200"); else passed++;
        tick(1'b1, 1'b0);
        checks++;
        if ({wr_en, wr_addr, hs, vs, de, line_cnt, resync, scanline} !== 26'h0 || rd_addr !== 10'h200)
            $display("FAIL midline_reset got=%h rd=%h exp=0 rd=200",
                     {wr_en, wr_addr, hs, vs, de, line_cnt, resync, scanline}, rd_addr);
        else passed++;
        tick(1'b1, 1'b1);
        checks++;
        if (rd_addr !== 10'h201 || wr_addr !== 10'h000 || wr_en !== 1'b1)
            $display("FAIL restart_counts rd=%h wr=%h we=%b exp=201/000/1", rd_addr, wr_addr, wr_en);
        else passed++;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 828; i++) begin
                tick(i >= 30, 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    nprint++;
                    if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end else passed++;
                if (resync) rs++;
            end
        end
        checks++;
        if (rs > 1) $display("FAIL relock_resync got=%0d exp<=1", rs); else passed++;
        checks++;
        if (wr_addr[9] !== 1'b1) $display("FAIL relock_bank got=%b exp=1", wr_addr[9]); else passed++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 25; p++) begin
            int lo, hi;
            lo = ($urandom_range(0, 3) == 0) ? 88 + $urandom_range(0, 3) : $urandom_range(1, 130);
            hi = $urandom_range(10, 900);
            for (int i = 0; i < lo + hi; i++) begin
                tick(i >= lo, 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    nprint++;
                    if (nprint <= 10) $display("FAIL model_cmp cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end else passed++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_hsync_lock();
        test_vsync();
        test_banks();
        test_de();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
